invader_bombs: RTL

- Downward projectile engine; the counterpart of the player laser.
- Once per fire interval, picks a firing column from an LFSR and spawns a bomb under the lowest live invader in that column.
- Moves the bomb down once per frame and pulses player_collision when the bomb overlaps the player sprite.
- Sits beside the laser/invaders blocks in the game core. Its player_collision output feeds score_logic.

---
 rtl/invader_bombs_pkg.sv | 36 +++
 rtl/invader_bombs_lfsr8.sv | 41 ++++
 rtl/invader_bombs.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/invader_bombs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : invader_bombs_pkg
// Description : Shared playfield geometry, bomb FSM states and the LFSR
//               start-column helper.
// Revision    : 1.0 - initial release
// ============================================================================
package invader_bombs_pkg;

    localparam int INVADER_W         = 16;
    localparam int INVADER_H         = 8;
    localparam int INVADER_SPACING_X = 24;
    localparam int INVADER_SPACING_Y = 16;
    localparam int INVADER_COLS      = 11;
    localparam int INVADER_ROWS      = 5;
    localparam int PLAYER_W          = 16;
    localparam int PLAYER_H          = 8;
    localparam int BOMB_W            = 2;
    localparam int BOMB_H            = 6;
    localparam int SCREEN_H          = 480;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_FALL   = 2'd2
    } bomb_state_e;

    // Folds the 4-bit LFSR nibble (0..15) onto the 11 formation columns.
    function automatic logic [3:0] start_col(input logic [7:0] lfsr_val);
        logic [3:0] s;
        s = lfsr_val[3:0];
        return (s >= 4'd11) ? (s - 4'd11) : s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/invader_bombs_lfsr8.sv
`default_nettype none
// ============================================================================
// Module      : lfsr8
// Description : 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) with seed reload
//               and step enable.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr8 #(
    parameter logic [7:0] SEED = 8'h5A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       step,
    output logic [7:0] value
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = SEED;
        end else if (step) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/invader_bombs.sv
`default_nettype none
// ============================================================================
// Module      : invader_bombs
// Description : Single downward bomb: picks a column, spawns under the lowest
//               live invader, falls per frame and flags player hits.
// Revision    : 1.0 - initial release
// ============================================================================
module invader_bombs
    import invader_bombs_pkg::*;
#(
    parameter int         BOMB_SPEED = 4,
    parameter int         FIRE_DELAY = 60,
    parameter logic [7:0] LFSR_SEED  = 8'h5A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arst,
    input  logic        frame,
    input  logic [54:0] invaders,
    input  logic [9:0]  invaders_x,
    input  logic [9:0]  invaders_y,
    input  logic [9:0]  player_x,
    input  logic [9:0]  player_y,
    output logic        bomb_active,
    output logic [9:0]  bomb_x,
    output logic [9:0]  bomb_y,
    output logic        player_collision
);

    localparam int CD_W = $clog2(FIRE_DELAY + 2);

    localparam logic [CD_W-1:0] c_cool_reload = CD_W'(FIRE_DELAY);
    localparam logic [9:0]      c_col_pitch   = 10'(INVADER_SPACING_X);
    localparam logic [9:0]      c_row_pitch   = 10'(INVADER_SPACING_Y);
    localparam logic [9:0]      c_bomb_x_off  = 10'((INVADER_W - BOMB_W) / 2);
    localparam logic [9:0]      c_inv_h       = 10'(INVADER_H);
    localparam logic [10:0]     c_speed       = 11'(BOMB_SPEED);
    localparam logic [10:0]     c_bomb_w      = 11'(BOMB_W);
    localparam logic [10:0]     c_bomb_h      = 11'(BOMB_H);
    localparam logic [10:0]     c_player_w    = 11'(PLAYER_W);
    localparam logic [10:0]     c_player_h    = 11'(PLAYER_H);
    localparam logic [10:0]     c_screen_h    = 11'(SCREEN_H);

    bomb_state_e     state_q,       state_d;
    logic [CD_W-1:0] cooldown_q,    cooldown_d;
    logic [3:0]      scan_col_q,    scan_col_d;
    logic [3:0]      scan_cnt_q,    scan_cnt_d;
    logic            bomb_active_q, bomb_active_d;
    logic [9:0]      bomb_x_q,      bomb_x_d;
    logic [9:0]      bomb_y_q,      bomb_y_d;
    logic            collision_q,   collision_d;

    logic       lfsr_step;
    logic [7:0] lfsr_value;

    lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (arst),
        .step  (lfsr_step),
        .value (lfsr_value)
    );

    // Lowest live invader in the column currently being scanned.
    logic       col_found;
    logic [2:0] col_row;
    logic [5:0] bit_idx;

    always_comb begin
        col_found = 1'b0;
        col_row   = 3'd0;
        bit_idx   = 6'd0;
        for (int r = 0; r < INVADER_ROWS; r++) begin
            bit_idx = 6'(r * INVADER_COLS) + {2'b00, scan_col_q};
            if (invaders[bit_idx]) begin
                col_found = 1'b1;
                col_row   = 3'(r);
            end
        end
    end

    logic [9:0] spawn_x;
    logic [9:0] spawn_y;

    assign spawn_x = invaders_x + 10'(scan_col_q) * c_col_pitch + c_bomb_x_off;
    assign spawn_y = invaders_y + 10'(col_row) * c_row_pitch + c_inv_h;

    // Hit test uses 11-bit arithmetic so the bottom edge never wraps.
    logic [10:0] y_next;
    logic [10:0] bx_ext;
    logic [10:0] px_ext;
    logic [10:0] py_ext;
    logic        hit;

    assign y_next = {1'b0, bomb_y_q} + c_speed;
    assign bx_ext = {1'b0, bomb_x_q};
    assign px_ext = {1'b0, player_x};
    assign py_ext = {1'b0, player_y};
    assign hit    = (bx_ext + c_bomb_w > px_ext) &&
                    (bx_ext < px_ext + c_player_w) &&
                    (y_next + c_bomb_h > py_ext) &&
                    (y_next < py_ext + c_player_h);

    always_comb begin
        state_d       = state_q;
        cooldown_d    = cooldown_q;
        scan_col_d    = scan_col_q;
        scan_cnt_d    = scan_cnt_q;
        bomb_active_d = bomb_active_q;
        bomb_x_d      = bomb_x_q;
        bomb_y_d      = bomb_y_q;
        collision_d   = 1'b0;
        lfsr_step     = 1'b0;

        if (arst) begin
            state_d       = ST_IDLE;
            cooldown_d    = c_cool_reload;
            scan_col_d    = 4'd0;
            scan_cnt_d    = 4'd0;
            bomb_active_d = 1'b0;
            bomb_x_d      = 10'd0;
            bomb_y_d      = 10'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (frame) begin
                        if (cooldown_q != '0) begin
                            cooldown_d = cooldown_q - CD_W'(1);
                        end else begin
                            state_d    = ST_SELECT;
                            scan_col_d = start_col(lfsr_value);
                            scan_cnt_d = 4'd0;
                            lfsr_step  = 1'b1;
                        end
                    end
                end

                ST_SELECT: begin
                    if (col_found) begin
                        bomb_x_d      = spawn_x;
                        bomb_y_d      = spawn_y;
                        bomb_active_d = 1'b1;
                        state_d       = ST_FALL;
                    end else if (scan_cnt_q == 4'd10) begin
                        state_d    = ST_IDLE;
                        cooldown_d = c_cool_reload;
                    end else begin
                        scan_col_d = (scan_col_q == 4'd10) ? 4'd0 : scan_col_q + 4'd1;
                        scan_cnt_d = scan_cnt_q + 4'd1;
                    end
                end

                ST_FALL: begin
                    if (frame) begin
                        if (hit) begin
                            collision_d   = 1'b1;
                            bomb_active_d = 1'b0;
                            state_d       = ST_IDLE;
                            cooldown_d    = c_cool_reload;
                        end else if (y_next >= c_screen_h) begin
                            bomb_active_d = 1'b0;
                            state_d       = ST_IDLE;
                            cooldown_d    = c_cool_reload;
                        end else begin
                            bomb_y_d = y_next[9:0];
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cooldown_q    <= c_cool_reload;
            scan_col_q    <= 4'd0;
            scan_cnt_q    <= 4'd0;
            bomb_active_q <= 1'b0;
            bomb_x_q      <= 10'd0;
            bomb_y_q      <= 10'd0;
            collision_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cooldown_q    <= cooldown_d;
            scan_col_q    <= scan_col_d;
            scan_cnt_q    <= scan_cnt_d;
            bomb_active_q <= bomb_active_d;
            bomb_x_q      <= bomb_x_d;
            bomb_y_q      <= bomb_y_d;
            collision_q   <= collision_d;
        end
    end

    assign bomb_active      = bomb_active_q;
    assign bomb_x           = bomb_x_q;
    assign bomb_y           = bomb_y_q;
    assign player_collision = collision_q;

endmodule
`default_nettype wire
